// File: rtl/zigzag_codec.sv
// Rail-fence (zigzag) encrypt/decrypt engine.
// Buffers a message until the token, then streams the permuted bytes out.
module zigzag_codec #(
  parameter int D_WIDTH = 8,
  parameter int KEY_WIDTH = 8,
  parameter int MAX_NOF_CHARS = 50,
  parameter int MAX_KEY = 16,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic                 mode,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);

  localparam int AW =
    (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, GEN, EMIT} state_t;

  state_t state;
  logic [D_WIDTH-1:0] msg_mem [DEPTH];
  logic [D_WIDTH-1:0] res_mem [DEPTH];

  logic [7:0] cnt, n, k, r, j, kc;
  logic [8:0] p, cyc, step, sum;
  logic enc, alt, last;
  logic ident, edge_r, wrap, is_tok, wr_msg;

  always_comb begin
    kc = (key > KEY_WIDTH'(MAX_KEY)) ? 8'(MAX_KEY) : 8'(key);
    is_tok = (data_i == START_DECRYPTION_TOKEN);
    wr_msg = (state == IDLE) && valid_i && !is_tok &&
             (cnt != 8'(MAX_NOF_CHARS));
  end

  // Next zigzag position: walk one rail at a time in ascending order.
  always_comb begin
    ident = (k <= 8'd1);
    cyc = {k, 1'b0} - 9'd2;
    edge_r = (r == 8'd0) || (r == k - 8'd1);
    if (ident)
      step = 9'd1;
    else if (edge_r)
      step = cyc;
    else if (alt)
      step = {r, 1'b0};
    else
      step = cyc - {r, 1'b0};
    sum = p + step;
    wrap = (sum >= {1'b0, n});
  end

  always_ff @(posedge clk) begin
    if (wr_msg)
      msg_mem[cnt[AW-1:0]] <= data_i;
    if (state == GEN)
      res_mem[p[AW-1:0]] <= msg_mem[j[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      k <= '0;
      r <= '0;
      j <= '0;
      p <= '0;
      enc <= 1'b0;
      alt <= 1'b0;
      last <= 1'b0;
      busy <= 1'b0;
      valid_o <= 1'b0;
      data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && is_tok) begin
            if (cnt != 8'd0) begin
              n <= cnt;
              k <= kc;
              enc <= mode;
              busy <= 1'b1;
              p <= '0;
              r <= '0;
              j <= '0;
              alt <= 1'b0;
              last <= 1'b0;
              state <= mode ? EMIT : GEN;
            end
          end else if (wr_msg) begin
            cnt <= cnt + 8'd1;
          end
        end
        GEN: begin
          if (j == n - 8'd1) begin
            j <= '0;
            state <= EMIT;
          end else begin
            j <= j + 8'd1;
            if (wrap) begin
              r <= r + 8'd1;
              p <= {1'b0, r} + 9'd1;
              alt <= 1'b0;
            end else begin
              p <= sum;
              alt <= ~alt;
            end
          end
        end
        EMIT: begin
          if (last) begin
            valid_o <= 1'b0;
            busy <= 1'b0;
            cnt <= '0;
            state <= IDLE;
          end else begin
            valid_o <= 1'b1;
            data_o <= enc ? msg_mem[p[AW-1:0]]
                          : res_mem[j[AW-1:0]];
            if (j == n - 8'd1) begin
              last <= 1'b1;
            end else begin
              j <= j + 8'd1;
              if (wrap) begin
                r <= r + 8'd1;
                p <= {1'b0, r} + 9'd1;
                alt <= 1'b0;
              end else begin
                p <= sum;
                alt <= ~alt;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_codec.sv
// Scoreboard bench for zigzag_codec: rail-fence model, queued expectations,
// independent output monitors for the default and a 4-deep instance.
module tb_zigzag_codec;

  typedef logic [7:0] bq_t[$];
  localparam logic [7:0] TOK = 8'hFA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data_i = '0;
  logic valid_i = 1'b0;
  logic [7:0] key = '0;
  logic mode = 1'b0;
  logic busy, valid_o;
  logic [7:0] data_o;

  logic [7:0] b_data_i = '0;
  logic b_valid_i = 1'b0;
  logic [7:0] b_key = '0;
  logic b_mode = 1'b0;
  logic b_busy, b_valid_o;
  logic [7:0] b_data_o;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b[$];
  logic [7:0] ea, eb;

  always #5 clk = ~clk;

  zigzag_codec dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .key(key), .mode(mode), .busy(busy), .data_o(data_o),
    .valid_o(valid_o)
  );

  zigzag_codec #(.MAX_NOF_CHARS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_i(b_data_i), .valid_i(b_valid_i),
    .key(b_key), .mode(b_mode), .busy(b_busy), .data_o(b_data_o),
    .valid_o(b_valid_o)
  );

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && valid_o) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected got %02h want none", data_o);
      end else begin
        ea = exp_q.pop_front();
        if (data_o !== ea) begin
          fails++;
          $display("FAIL out_data got %02h want %02h", data_o, ea);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && b_valid_o) begin
      tests++;
      if (exp_b.size() == 0) begin
        fails++;
        $display("FAIL out4_unexpected got %02h want none", b_data_o);
      end else begin
        eb = exp_b.pop_front();
        if (b_data_o !== eb) begin
          fails++;
          $display("FAIL out4_data got %02h want %02h", b_data_o, eb);
        end
      end
    end
  end

  function automatic bq_t s2q(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rnd_msg(int len);
    bq_t q;
    for (int i = 0; i < len; i++)
      q.push_back(8'($urandom_range(0, 249)));
    return q;
  endfunction

  // Reference: group indices by their rail on the zigzag, rails in order.
  function automatic bq_t model(bq_t msg, int key_v, bit enc, int maxc);
    int n = (msg.size() < maxc) ? msg.size() : maxc;
    int k = (key_v > 16) ? 16 : ((key_v < 1) ? 1 : key_v);
    int cyc = 2 * (k - 1);
    int ord[$];
    bq_t res;
    for (int r = 0; r < k; r++)
      for (int i = 0; i < n; i++) begin
        int m = (k == 1) ? 0 : i % cyc;
        int rl = (m < k) ? m : cyc - m;
        if (rl == r) ord.push_back(i);
      end
    for (int i = 0; i < n; i++) res.push_back(8'h00);
    for (int j = 0; j < n; j++)
      if (enc) res[j] = msg[ord[j]];
      else res[ord[j]] = msg[j];
    return res;
  endfunction

  task automatic run_msg(bq_t msg, int key_v, bit enc, bq_t exp, bit junk);
    int n = exp.size();
    int first = -1;
    int nv = 0;
    int fall = -1;
    foreach (exp[i]) exp_q.push_back(exp[i]);
    foreach (msg[i]) begin
      @(negedge clk);
      data_i = msg[i];
      valid_i = 1'b1;
      key = 8'($urandom);
      mode = 1'($urandom);
    end
    @(negedge clk);
    data_i = TOK;
    valid_i = 1'b1;
    key = 8'(key_v);
    mode = enc;
    @(posedge clk);
    #1;
    check("busy_on", busy, 1);
    valid_i = 1'b0;
    for (int c = 1; c <= 4 * n + 8; c++) begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        if (first < 0) first = c;
        nv++;
      end
      if (!busy) begin
        fall = c;
        break;
      end
      if (junk) begin
        @(negedge clk);
        data_i = ($urandom_range(0, 3) == 0) ? TOK : 8'($urandom);
        valid_i = 1'b1;
        key = 8'($urandom);
        mode = 1'($urandom);
      end
    end
    valid_i = 1'b0;
    check("busy_len", fall, enc ? n + 1 : 2 * n + 1);
    check("first_valid", first, enc ? 1 : n + 1);
    check("valid_count", nv, n);
  endtask

  initial begin
    bq_t m, c, pt;
    int seen;
    int bad;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);

    pt = s2q("WEAREDISCOVEREDFLEEATONCE");
    c = s2q("WECRLTEERDSOEEFEAOCAIVDEN");
    run_msg(pt, 3, 1'b1, c, 1'b0);
    run_msg(c, 3, 1'b0, pt, 1'b0);

    m = s2q("HELLO");
    run_msg(m, 2, 1'b1, s2q("HLOEL"), 1'b0);
    run_msg(s2q("HLOEL"), 2, 1'b0, m, 1'b0);
    run_msg(m, 1, 1'b1, m, 1'b0);
    run_msg(m, 1, 1'b0, m, 1'b0);
    run_msg(m, 7, 1'b1, m, 1'b0);
    run_msg(m, 7, 1'b0, m, 1'b0);

    m = rnd_msg(40);
    run_msg(m, 40, 1'b1, model(m, 16, 1'b1, 50), 1'b0);
    run_msg(m, 40, 1'b0, model(m, 16, 1'b0, 50), 1'b0);

    @(negedge clk);
    data_i = TOK;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (busy) bad++;
    end
    check("token_first_busy", bad, 0);

    foreach (exp_b[i]) exp_b.delete(i);
    exp_b = s2q("ACBD");
    m = s2q("ABCDEF");
    foreach (m[i]) begin
      @(negedge clk);
      b_data_i = m[i];
      b_valid_i = 1'b1;
    end
    @(negedge clk);
    b_data_i = TOK;
    b_key = 8'd2;
    b_mode = 1'b1;
    @(negedge clk);
    b_valid_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!b_busy) break;
      seen++;
    end
    check("max4_busy_len", seen, 4);
    check("max4_left", exp_b.size(), 0);

    exp_q.push_back("W");
    exp_q.push_back("E");
    exp_q.push_back("C");
    foreach (pt[i]) begin
      @(negedge clk);
      data_i = pt[i];
      valid_i = 1'b1;
    end
    @(negedge clk);
    data_i = TOK;
    key = 8'd3;
    mode = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    check("rst_wait_3rd", seen, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", valid_o, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_msg(c, 3, 1'b0, pt, 1'b0);

    m = rnd_msg(20);
    run_msg(m, 5, 1'b0, model(m, 5, 1'b0, 50), 1'b1);
    m = rnd_msg(13);
    run_msg(m, 4, 1'b1, model(m, 4, 1'b1, 50), 1'b0);

    for (int t = 0; t < 25; t++) begin
      int len = $urandom_range(1, 60);
      int kv = $urandom_range(0, 40);
      bit e = 1'($urandom);
      m = rnd_msg(len);
      run_msg(m, kv, e, model(m, kv, e, 50), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zigzag_codec.md
# zigzag_codec

Parametrised rail-fence (zigzag) engine for the message-decryption datapath, working in either direction. Collects a message byte-stream until the start token, then streams the result out one byte per cycle. Handles any key from 1 to `MAX_KEY`, runs encryption and decryption in the same block, and uses a sequential position generator instead of combinational division loops. Sits beside the other cipher blocks, behind the input demux, with the same valid/busy interface.

## Interface
- `D_WIDTH`, 8: character width.
- `KEY_WIDTH`, 8: key port width.
- `MAX_NOF_CHARS`, 50: buffer depth, 1..255.
- `MAX_KEY`, 16: largest rail count supported. Larger keys are clamped to `MAX_KEY`.
- `START_DECRYPTION_TOKEN`, 8'hFA: end-of-message / start-processing token.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_i` in D_WIDTH: input character or token.
- `valid_i` in 1: qualifies `data_i`.
- `key` in KEY_WIDTH: rail count, sampled on the token cycle.
- `mode` in 1: 0 = decrypt, 1 = encrypt; sampled on the token cycle.
- `busy` out 1: high from the cycle after token acceptance until output completes.
- `data_o` out D_WIDTH: result character, registered.
- `valid_o` out 1: qualifies `data_o`.

## Operation
- States are IDLE, GEN, EMIT.
- **IDLE**
  - When `valid_i` is high and `data_i` is not the token: write to `buf[cnt]` and increment `cnt`.
  - If `cnt == MAX_NOF_CHARS`, further characters are dropped silently.
- **Token acceptance**
  - A token with `cnt == 0` is ignored and the block stays in IDLE.
  - Otherwise latch `N = cnt`, `k = clamp(key)` and `mode`, and set `busy`.
  - Go to EMIT if encrypting, or to GEN if decrypting.
- **Position generator** (shared by both modes)
  - `cyc = 2*(k-1)`.
  - Rail `r` starts at `p = r`.
  - Rails 0 and k-1 step by `cyc`. Middle rails alternate steps `cyc-2r` and `2r`, starting with `cyc-2r`.
  - When `p + step >= N`, move to rail `r+1` with `p = r+1`.
  - `k <= 1` gives the identity sequence 0..N-1.
  - Exactly one position is produced per cycle, with index `j` running 0..N-1. Generation stops at `j == N-1`, so empty rails (`r >= N`) are never visited.
  - All arithmetic is 9-bit, so no wrap occurs for `p + step` with `N <= 255`.
- **Encrypt (EMIT)**
  - Each cycle: `data_o <= buf[p]`, `valid_o <= 1`.
- **Decrypt (GEN)**
  - Each cycle: `out[p] <= buf[j]`.
  - After N cycles, go to EMIT. In decrypt, EMIT reads `out[0..N-1]` sequentially.
- **End of EMIT**
  - After N outputs, drop `valid_o` and `busy`, clear `cnt`, return to IDLE.
- **While busy**
  - `valid_i` is ignored entirely, including tokens.
  - `key` and `mode` changes have no effect.

## Timing
- Reset (async assert, sync release): state IDLE, `cnt = 0`, `busy = 0`, `valid_o = 0`, `data_o = 0`. Buffer contents are don't-care.
- Token accepted at edge E0: `busy` is 1 after E0.
- Encrypt:
  - `valid_o` is high after edges E0+1 .. E0+N, for N consecutive cycles with no gaps.
  - `busy` and `valid_o` fall together after edge E0+N+1.
- Decrypt:
  - GEN occupies edges E0+1 .. E0+N.
  - `valid_o` is high after edges E0+N+1 .. E0+2N.
  - `busy` and `valid_o` fall after E0+2N+1.
- A new message character is accepted on the first cycle `busy` is low (back-to-back messages are allowed).
- `data_o` holds its last value when `valid_o` is low.
- Reset mid-GEN or mid-EMIT aborts immediately: outputs go to reset values, the partial message is discarded, and no further `valid_o` is produced.

## Test plan
- Encrypt "WEAREDISCOVEREDFLEEATONCE", key 3 -> 25 valid bytes "WECRLTEERDSOEEFEAOCAIVDEN", contiguous, starting 2 cycles after token. Decrypt of that ciphertext, key 3 -> original plaintext; `busy` high for 2N+1 cycles.
- "HELLO": encrypt key 2 -> "HLOEL"; decrypt "HLOEL" key 2 -> "HELLO". Key 1 and key 7 (≥N) -> "HELLO" unchanged in both modes.
- Key 40 with `MAX_KEY = 16` -> behaves identically to key 16. Token as first byte -> no `busy`, no output.
- `MAX_NOF_CHARS = 4`: send "ABCDEF" + token, encrypt key 2 -> "ACBD" only; E and F are dropped.
- Deassert `rst_n` at the 3rd output byte -> `valid_o`/`busy` go to 0 asynchronously. A fresh message after release decodes correctly.
- Send characters and a token during `busy` -> ignored. A second message sent immediately after `busy` falls -> correct, independent result.
